// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter letting NUM_MASTERS classic Wishbone masters share one slave.
// One cycle of grant latency, no preemption, and an optional watchdog that errors out stalled strobes.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int GRANULARITY = 8,
  parameter int TIMEOUT     = 256,
  localparam int SEL_WIDTH  = DATA_WIDTH / GRANULARITY
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic                              s_we_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_stb_o,
  output logic                              s_cyc_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0] r_grant;
  logic [LW-1:0]          r_last;
  logic [CW-1:0]          r_cnt;

  logic          w_busy;
  logic          w_found;
  logic [LW-1:0] w_win;
  logic          w_stb_req;
  logic          w_term;
  logic          w_timeout;

  // While granted, r_last always equals the owner's index, so it doubles as the mux select.
  assign w_busy    = |r_grant;
  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_stb_req = w_busy & m_cyc_i[r_last] & m_stb_i[r_last];
  assign w_timeout = (TIMEOUT > 0) && w_stb_req && !w_term && (r_cnt == CW'(TIMEOUT - 1));

  // Round-robin scan starting at the master after the last winner.
  always_comb begin
    logic [LW-1:0] v_idx;
    w_found = 1'b0;
    w_win   = r_last;
    v_idx   = r_last;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      v_idx = LW'((int'(r_last) + i) % NUM_MASTERS);
      if (!w_found && m_cyc_i[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Slave-side mux and per-master termination routing.
  always_comb begin
    s_adr_o = m_adr_i[int'(r_last) * ADDR_WIDTH +: ADDR_WIDTH];
    s_dat_o = m_dat_i[int'(r_last) * DATA_WIDTH +: DATA_WIDTH];
    s_cyc_o = w_busy & m_cyc_i[r_last];
    s_stb_o = w_stb_req & ~w_timeout;
    s_we_o  = w_busy & m_we_i[r_last];
    if (w_busy) begin
      s_sel_o = m_sel_i[int'(r_last) * SEL_WIDTH +: SEL_WIDTH];
    end else begin
      s_sel_o = {SEL_WIDTH{1'b0}};
    end
    m_dat_o = s_dat_i;
    m_ack_o = r_grant & {NUM_MASTERS{s_ack_i}};
    m_err_o = r_grant & {NUM_MASTERS{s_err_i | w_timeout}};
    m_rty_o = r_grant & {NUM_MASTERS{s_rty_i}};
    grant_o = r_grant;
  end

  // Grant ownership, last-winner pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= {NUM_MASTERS{1'b0}};
      r_last  <= LAST_RST;
      r_cnt   <= {CW{1'b0}};
    end else begin
      if (!w_busy) begin
        if (w_found) begin
          r_grant <= NUM_MASTERS'(1'b1) << w_win;
          r_last  <= w_win;
        end
      end else if (!m_cyc_i[r_last]) begin
        r_grant <= {NUM_MASTERS{1'b0}};
      end
      if ((TIMEOUT > 0) && w_stb_req && !w_term && !w_timeout) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= {CW{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench: a 2-master arbiter with an 8-cycle watchdog and a 3-master arbiter
// with the default watchdog, each fed hand-computed cycle-by-cycle vectors.
module tb_wb_rr_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Two-master instance
  logic            rst2;
  logic [2*AW-1:0] m_adr2;
  logic [2*DW-1:0] m_dat2;
  logic [1:0]      m_we2, m_stb2, m_cyc2;
  logic [2*SW-1:0] m_sel2;
  logic [DW-1:0]   m_dat_o2, s_dat_o2, s_dat_i2;
  logic [1:0]      m_ack2, m_err2, m_rty2, grant2;
  logic [AW-1:0]   s_adr2;
  logic            s_we2, s_stb2, s_cyc2, s_ack2, s_err2, s_rty2;
  logic [SW-1:0]   s_sel2;

  // Three-master instance
  logic            rst3;
  logic [3*AW-1:0] m_adr3;
  logic [3*DW-1:0] m_dat3;
  logic [2:0]      m_we3, m_stb3, m_cyc3;
  logic [3*SW-1:0] m_sel3;
  logic [DW-1:0]   m_dat_o3, s_dat_o3, s_dat_i3;
  logic [2:0]      m_ack3, m_err3, m_rty3, grant3;
  logic [AW-1:0]   s_adr3;
  logic            s_we3, s_stb3, s_cyc3, s_ack3, s_err3, s_rty3;
  logic [SW-1:0]   s_sel3;

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a, a + 32'h0000_0007, 32'hCAFE_0000 | a};
  endfunction

  assign s_dat_i2 = ram_word(s_adr2);
  assign s_dat_i3 = ram_word(s_adr3);

  wb_rr_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULARITY(8), .TIMEOUT(8)) dut2 (
    .clk(clk), .rst(rst2), .m_adr_i(m_adr2), .m_dat_i(m_dat2), .m_we_i(m_we2), .m_sel_i(m_sel2),
    .m_stb_i(m_stb2), .m_cyc_i(m_cyc2), .m_dat_o(m_dat_o2), .m_ack_o(m_ack2), .m_err_o(m_err2),
    .m_rty_o(m_rty2), .s_adr_o(s_adr2), .s_dat_o(s_dat_o2), .s_we_o(s_we2), .s_sel_o(s_sel2),
    .s_stb_o(s_stb2), .s_cyc_o(s_cyc2), .s_dat_i(s_dat_i2), .s_ack_i(s_ack2), .s_err_i(s_err2),
    .s_rty_i(s_rty2), .grant_o(grant2));

  wb_rr_arbiter #(.NUM_MASTERS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULARITY(8), .TIMEOUT(256)) dut3 (
    .clk(clk), .rst(rst3), .m_adr_i(m_adr3), .m_dat_i(m_dat3), .m_we_i(m_we3), .m_sel_i(m_sel3),
    .m_stb_i(m_stb3), .m_cyc_i(m_cyc3), .m_dat_o(m_dat_o3), .m_ack_o(m_ack3), .m_err_o(m_err3),
    .m_rty_o(m_rty3), .s_adr_o(s_adr3), .s_dat_o(s_dat_o3), .s_we_o(s_we3), .s_sel_o(s_sel3),
    .s_stb_o(s_stb3), .s_cyc_o(s_cyc3), .s_dat_i(s_dat_i3), .s_ack_i(s_ack3), .s_err_i(s_err3),
    .s_rty_i(s_rty3), .grant_o(grant3));

  typedef struct {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic       err;
    logic       rty;
    logic [1:0] grant;
    logic       scyc;
    logic       sstb;
    logic [1:0] mack;
    logic [1:0] merr;
    logic [1:0] mrty;
  } vec_t;

  vec_t vecs[22];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [AW-1:0] ADR0 = 32'h0000_0100;
  localparam logic [AW-1:0] ADR1 = 32'h0000_2200;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] exp_adr;
    logic [2:0]    order[3];

    // rst cyc stb ack err rty | grant scyc sstb mack merr mrty
    vecs[0]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[2]  = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[3]  = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00};
    vecs[4]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[5]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00};
    vecs[8]  = '{1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[10] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00};
    vecs[11] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[12] = '{1'b0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[13] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00};
    vecs[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[15] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[16] = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[17] = '{1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[18] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00};
    vecs[19] = '{1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10};
    vecs[20] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
    vecs[21] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};

    rst2 = 1'b1; m_adr2 = {ADR1, ADR0}; m_dat2 = '0; m_we2 = 2'b00; m_sel2 = '1;
    m_stb2 = 2'b00; m_cyc2 = 2'b00; s_ack2 = 1'b0; s_err2 = 1'b0; s_rty2 = 1'b0;
    rst3 = 1'b1; m_adr3 = '0; m_dat3 = '0; m_we3 = 3'b000; m_sel3 = '0;
    m_stb3 = 3'b000; m_cyc3 = 3'b000; s_ack3 = 1'b0; s_err3 = 1'b0; s_rty3 = 1'b0;
    tick();
    rst3 = 1'b0;

    // Table: reset, single access, alternation, cyc-without-stb, err/rty routing
    for (int i = 0; i < 22; i++) begin
      rst2 = vecs[i].rst; m_cyc2 = vecs[i].cyc; m_stb2 = vecs[i].stb;
      s_ack2 = vecs[i].ack; s_err2 = vecs[i].err; s_rty2 = vecs[i].rty;
      @(negedge clk);
      chk($sformatf("v%0d grant", i), grant2, vecs[i].grant);
      chk($sformatf("v%0d s_cyc", i), s_cyc2, vecs[i].scyc);
      chk($sformatf("v%0d s_stb", i), s_stb2, vecs[i].sstb);
      chk($sformatf("v%0d m_ack", i), m_ack2, vecs[i].mack);
      chk($sformatf("v%0d m_err", i), m_err2, vecs[i].merr);
      chk($sformatf("v%0d m_rty", i), m_rty2, vecs[i].mrty);
      if (vecs[i].grant != 2'b00) begin
        exp_adr = vecs[i].grant[0] ? ADR0 : ADR1;
        chk($sformatf("v%0d s_adr", i), s_adr2, exp_adr);
        chk($sformatf("v%0d m_dat", i), m_dat_o2, ram_word(exp_adr));
      end
      tick();
    end

    // Master 0 bursts 4 beats while master 1 waits
    m_cyc2 = 2'b11; m_stb2 = 2'b11; m_adr2[31:0] = 32'h0;
    @(negedge clk); chk("burst idle grant", grant2, 2'b00); tick();
    for (int b = 0; b < 4; b++) begin
      m_adr2[31:0] = 32'(b * 16); s_ack2 = 1'b1;
      @(negedge clk);
      chk($sformatf("burst%0d grant", b), grant2, 2'b01);
      chk($sformatf("burst%0d m_ack", b), m_ack2, 2'b01);
      chk($sformatf("burst%0d s_adr", b), s_adr2, 32'(b * 16));
      chk($sformatf("burst%0d m_dat", b), m_dat_o2, ram_word(32'(b * 16)));
      tick();
    end
    s_ack2 = 1'b0; m_cyc2 = 2'b10; m_stb2 = 2'b10;
    @(negedge clk); chk("burst drop grant", grant2, 2'b01); chk("burst drop s_cyc", s_cyc2, 1'b0); tick();
    @(negedge clk); chk("burst gap grant", grant2, 2'b00); tick();
    @(negedge clk); chk("burst m1 grant", grant2, 2'b10); tick();
    m_cyc2 = 2'b00; m_stb2 = 2'b00;
    tick(); tick();

    // Watchdog: slave never acks, then ack arrives on the timeout cycle
    m_cyc2 = 2'b01; m_stb2 = 2'b01;
    @(negedge clk); chk("wd idle grant", grant2, 2'b00); tick();
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      chk($sformatf("wd%0d m_err", j), m_err2, (j == 8) ? 2'b01 : 2'b00);
      chk($sformatf("wd%0d s_stb", j), s_stb2, (j == 8) ? 1'b0 : 1'b1);
      tick();
    end
    for (int j = 1; j <= 8; j++) begin
      s_ack2 = (j == 8);
      @(negedge clk);
      chk($sformatf("wdack%0d m_err", j), m_err2, 2'b00);
      chk($sformatf("wdack%0d m_ack", j), m_ack2, (j == 8) ? 2'b01 : 2'b00);
      chk($sformatf("wdack%0d s_stb", j), s_stb2, 1'b1);
      tick();
    end
    s_ack2 = 1'b0; m_cyc2 = 2'b00; m_stb2 = 2'b00;
    tick(); tick();

    // Reset mid-write while master 0 (the last winner) owns the bus
    m_adr2[31:0] = 32'h40; m_we2 = 2'b01; m_sel2 = {16'hFFFF, 16'h00F0};
    m_cyc2 = 2'b01; m_stb2 = 2'b01;
    @(negedge clk); chk("rst idle grant", grant2, 2'b00); tick();
    m_cyc2 = 2'b11; m_stb2 = 2'b11; rst2 = 1'b1;
    @(negedge clk);
    chk("rst wr grant", grant2, 2'b01); chk("rst wr s_we", s_we2, 1'b1);
    chk("rst wr s_sel", s_sel2, 16'h00F0); chk("rst wr s_cyc", s_cyc2, 1'b1);
    tick();
    rst2 = 1'b0; s_ack2 = 1'b1;
    @(negedge clk);
    chk("rst after grant", grant2, 2'b00); chk("rst after s_cyc", s_cyc2, 1'b0);
    chk("rst after s_stb", s_stb2, 1'b0); chk("rst after m_ack", m_ack2, 2'b00);
    tick();
    s_ack2 = 1'b0;
    @(negedge clk); chk("rst first winner", grant2, 2'b01); tick();
    m_cyc2 = 2'b00; m_stb2 = 2'b00; m_we2 = 2'b00;
    tick();

    // Three masters: master 1 wins alone, then all request; order must be 2,0,1
    m_cyc3 = 3'b010; m_stb3 = 3'b010;
    @(negedge clk); chk("n3 idle grant", grant3, 3'b000); tick();
    @(negedge clk); chk("n3 m1 grant", grant3, 3'b010); tick();
    m_cyc3 = 3'b000; m_stb3 = 3'b000;
    tick(); tick();
    order[0] = 3'd2; order[1] = 3'd0; order[2] = 3'd1;
    m_cyc3 = 3'b111; m_stb3 = 3'b111;
    @(negedge clk); chk("n3 rr idle", grant3, 3'b000); tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk($sformatf("n3 rr%0d grant", k), grant3, 3'b001 << order[k]); tick();
      m_cyc3 = m_cyc3 & ~(3'b001 << order[k]); m_stb3 = m_cyc3;
      @(negedge clk); chk($sformatf("n3 rr%0d s_cyc", k), s_cyc3, 1'b0); tick();
      @(negedge clk); chk($sformatf("n3 rr%0d gap", k), grant3, 3'b000); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
N-master to 1-slave Wishbone (classic, non-pipelined) arbiter with round-robin fairness and an optional bus-timeout watchdog. It is the next-generation fabric for the single-CPU-plus-RAM top level. It lets the CPU instruction/data caches, a DMA engine or a debug master share one wb_ram. It sits between the masters' wb_* ports and the slave's wb_* ports, adding one cycle of arbitration latency at the start of each cycle.

Parameters:
NUM_MASTERS, 2, number of master ports (≥1)
ADDR_WIDTH, 32, Wishbone address width
DATA_WIDTH, 128, Wishbone data width
GRANULARITY, 8, bits per select lane; SEL_WIDTH = DATA_WIDTH/GRANULARITY
TIMEOUT, 256, cycles a strobed transfer may wait before forced error; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m_adr_i  in  NUM_MASTERS*ADDR_WIDTH  packed master addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed master write data
m_we_i  in  NUM_MASTERS  write enables
m_sel_i  in  NUM_MASTERS*SEL_WIDTH  packed byte selects
m_stb_i  in  NUM_MASTERS  strobes
m_cyc_i  in  NUM_MASTERS  cycle requests
m_dat_o  out  DATA_WIDTH  slave read data broadcast to all masters
m_ack_o  out  NUM_MASTERS  per-master ack
m_err_o  out  NUM_MASTERS  per-master err
m_rty_o  out  NUM_MASTERS  per-master rty
s_adr_o  out  ADDR_WIDTH  to slave
s_dat_o  out  DATA_WIDTH  to slave
s_we_o  out  1  to slave
s_sel_o  out  SEL_WIDTH  to slave
s_stb_o  out  1  to slave
s_cyc_o  out  1  to slave
s_dat_i  in  DATA_WIDTH  from slave
s_ack_i  in  1  from slave
s_err_i  in  1  from slave
s_rty_i  in  1  from slave
grant_o  out  NUM_MASTERS  one-hot current grant (debug/observability)

Behaviour:
- Clock is clk; reset rst is synchronous and active-high, sampled on the rising clk edge.
- State: grant register (one-hot or zero), last-winner pointer, timeout counter.
- Reset: grant=0, last=NUM_MASTERS-1 (master 0 has top priority first), counter=0.
- Reset output values: all s_* outputs 0 except s_dat_o/s_adr_o (don't-care, tie to muxed value); all m_ack/err/rty 0; grant_o=0.
- IDLE (grant=0): if any m_cyc_i high, the next edge grants the first requester scanning last+1, last+2, … mod NUM_MASTERS, and sets last to the winner. No slave signals are driven in this cycle.
- BUSY (grant=k): s_adr/dat/we/sel/stb/cyc = master k's signals, combinationally muxed. s_ack/err/rty route combinationally to master k only; other masters see 0. m_dat_o = s_dat_i unconditionally.
- Grant is held while m_cyc_i[k] is high; requests from other masters are ignored (no preemption). Multiple stb/ack beats per cyc are allowed.
- Release: m_cyc_i[k] low → grant cleared at the next edge. A new grant can be issued at the following edge, so there is a minimum of 1 idle cycle between owners. s_cyc_o follows m_cyc_i[k], so it drops the same cycle the master drops it.
- Watchdog (TIMEOUT>0): counter increments each cycle s_cyc_o&s_stb_o&!(s_ack_i|s_err_i|s_rty_i). It clears on any termination or when s_stb_o is low. When the counter == TIMEOUT-1 and still unterminated, m_err_o[k] pulses high for one cycle, s_stb_o is forced low that cycle, and the counter clears. The cycle stays granted; the master decides whether to drop cyc.
- A late slave ack in the same cycle as the timeout: slave termination wins and no err is generated.
- Simultaneous requests: round-robin from last+1. NUM_MASTERS=1 degenerates to a pass-through with 1-cycle grant latency.
- A master raising and dropping cyc before grant is never serviced and is not an error.
- rst asserted mid-transfer: grant=0 after the edge, so s_cyc_o/s_stb_o are 0 next cycle and any in-flight ack is discarded.
- Width rules: DATA_WIDTH must be a multiple of GRANULARITY. Counter width is clog2(TIMEOUT+1).

Test Plan:
- Reset release, m_cyc_i=2'b01 with m_stb at cycle 0: grant_o=01 at cycle 1, s_stb_o=1 at cycle 1, RAM ack routed to m_ack_o[0] only, m_ack_o[1]=0.
- Both masters request continuously, each doing one single-beat access then dropping cyc: grants alternate 01,00,10,00,01…; each master gets every other transfer.
- Master 0 holds cyc for 4 beats (addresses 0x00,0x10,0x20,0x30) while master 1 requests: master 1 is not granted until 2 cycles after master 0's cyc falls; read data 128-bit values match RAM contents.
- TIMEOUT=8, slave never acks: m_err_o[k] high exactly in the 8th stalled cycle, s_stb_o low that cycle; with ack in that same cycle, only m_ack_o is asserted.
- rst pulsed mid-write with sel=16'h00F0: s_cyc_o=0 the cycle after the edge, grant_o=0, and after release master 0 wins first regardless of the prior winner.
- NUM_MASTERS=3 with master 1 last winner and all three requesting: grant order is 2,0,1.
